// File: rtl/control_multiciclo.sv
// Multicycle datapath controller: 12-state FSM with a combinational control decode.
// Memory states optionally stall on memReady; unknown opcodes raise illegalOp and refetch.
module control_multiciclo #(
  parameter int unsigned OPCODE_W      = 6,
  parameter int unsigned ALUOP_W       = 2,
  parameter int unsigned MEM_HANDSHAKE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opCode,
  input  logic                memReady,
  output logic                pcWrite,
  output logic                pcWriteCond,
  output logic                iorD,
  output logic                memRead,
  output logic                memWrite,
  output logic                irWrite,
  output logic                memtoReg,
  output logic                aluSrcA,
  output logic                regWrite,
  output logic                regDst,
  output logic [1:0]          pcSource,
  output logic [1:0]          aluSrcB,
  output logic [ALUOP_W-1:0]  aluOp,
  output logic [3:0]          state,
  output logic                illegalOp
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExec    = 4'd6,
    StRwb     = 4'd7,
    StBeq     = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11
  } state_t;

  localparam logic [OPCODE_W-1:0] OpRtype = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OpLw    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OpSw    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OpBeq   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OpAddi  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OpJ     = OPCODE_W'(6'b000010);

  localparam logic [ALUOP_W-1:0] AluAdd   = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] AluSub   = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] AluFunct = ALUOP_W'(2'b10);

  state_t r_state;
  logic   w_mem_rdy;
  logic   w_op_legal;

  assign w_mem_rdy  = (MEM_HANDSHAKE != 0) ? memReady : 1'b1;
  assign w_op_legal = (opCode == OpRtype) || (opCode == OpLw) || (opCode == OpSw) ||
                      (opCode == OpBeq) || (opCode == OpAddi) || (opCode == OpJ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StFetch;
    end else begin
      case (r_state)
        StFetch:  if (w_mem_rdy) r_state <= StDecode;
        StDecode: begin
          if (opCode == OpRtype)                       r_state <= StExec;
          else if ((opCode == OpLw) || (opCode == OpSw)) r_state <= StMemAdr;
          else if (opCode == OpBeq)                    r_state <= StBeq;
          else if (opCode == OpAddi)                   r_state <= StAddiEx;
          else if (opCode == OpJ)                      r_state <= StJump;
          else                                         r_state <= StFetch;
        end
        StMemAdr: r_state <= (opCode == OpLw) ? StMemRd : StMemWr;
        StMemRd:  if (w_mem_rdy) r_state <= StMemWb;
        StMemWb:  r_state <= StFetch;
        StMemWr:  if (w_mem_rdy) r_state <= StFetch;
        StExec:   r_state <= StRwb;
        StRwb:    r_state <= StFetch;
        StBeq:    r_state <= StFetch;
        StAddiEx: r_state <= StAddiWb;
        StAddiWb: r_state <= StFetch;
        StJump:   r_state <= StFetch;
        default:  r_state <= StFetch;
      endcase
    end
  end

  assign state = r_state;

  // Reset gates every control to 0, even though r_state already reads FETCH.
  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memtoReg    = 1'b0;
    aluSrcA     = 1'b0;
    regWrite    = 1'b0;
    regDst      = 1'b0;
    pcSource    = 2'b00;
    aluSrcB     = 2'b00;
    aluOp       = AluAdd;
    illegalOp   = 1'b0;
    if (!reset) begin
      case (r_state)
        StFetch: begin
          memRead = 1'b1;
          aluSrcB = 2'b01;
          irWrite = w_mem_rdy;
          pcWrite = w_mem_rdy;
        end
        StDecode: begin
          aluSrcB   = 2'b11;
          illegalOp = !w_op_legal;
        end
        StMemAdr: begin
          aluSrcA = 1'b1;
          aluSrcB = 2'b10;
        end
        StMemRd: begin
          memRead = 1'b1;
          iorD    = 1'b1;
        end
        StMemWb: begin
          regWrite = 1'b1;
          memtoReg = 1'b1;
        end
        StMemWr: begin
          memWrite = 1'b1;
          iorD     = 1'b1;
        end
        StExec: begin
          aluSrcA = 1'b1;
          aluOp   = AluFunct;
        end
        StRwb: begin
          regWrite = 1'b1;
          regDst   = 1'b1;
        end
        StBeq: begin
          aluSrcA     = 1'b1;
          aluOp       = AluSub;
          pcWriteCond = 1'b1;
          pcSource    = 2'b01;
        end
        StAddiEx: begin
          aluSrcA = 1'b1;
          aluSrcB = 2'b10;
        end
        StAddiWb: regWrite = 1'b1;
        StJump: begin
          pcWrite  = 1'b1;
          pcSource = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_multiciclo.sv
// Scoreboard bench: stimulus pushes hand-derived expected control words per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_control_multiciclo;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opCode;
  logic       memReady;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       memtoReg, aluSrcA, regWrite, regDst, illegalOp;
  logic [1:0] pcSource, aluSrcB, aluOp;
  logic [3:0] state;

  control_multiciclo #(
    .OPCODE_W     (6),
    .ALUOP_W      (2),
    .MEM_HANDSHAKE(1)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .opCode     (opCode),
    .memReady   (memReady),
    .pcWrite    (pcWrite),
    .pcWriteCond(pcWriteCond),
    .iorD       (iorD),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .irWrite    (irWrite),
    .memtoReg   (memtoReg),
    .aluSrcA    (aluSrcA),
    .regWrite   (regWrite),
    .regDst     (regDst),
    .pcSource   (pcSource),
    .aluSrcB    (aluSrcB),
    .aluOp      (aluOp),
    .state      (state),
    .illegalOp  (illegalOp)
  );

  always #5 clk = ~clk;

  // {state, pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memtoReg,
  //  aluSrcA, regWrite, regDst, pcSource, aluSrcB, aluOp, illegalOp}
  typedef logic [20:0] ctl_t;

  ctl_t q_exp[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   stim_done = 1'b0;

  function automatic ctl_t mk(input logic [3:0] st, input logic pw, input logic pwc,
                              input logic iord, input logic mr, input logic mw,
                              input logic irw, input logic m2r, input logic asa,
                              input logic rw, input logic rd, input logic [1:0] ps,
                              input logic [1:0] asb, input logic [1:0] aop,
                              input logic ill);
    return {st, pw, pwc, iord, mr, mw, irw, m2r, asa, rw, rd, ps, asb, aop, ill};
  endfunction

  // Hand-written control table for each state.
  function automatic ctl_t exp_ctl(input int st, input logic rdy, input logic rst,
                                   input logic ill);
    if (rst) return '0;
    case (st)
      0:  return mk(4'd0,  rdy, 0, 0, 1, 0, rdy, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0);
      1:  return mk(4'd1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00, ill);
      2:  return mk(4'd2,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 0);
      3:  return mk(4'd3,  0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      4:  return mk(4'd4,  0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      5:  return mk(4'd5,  0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      6:  return mk(4'd6,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b10, 0);
      7:  return mk(4'd7,  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 0);
      8:  return mk(4'd8,  0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 2'b01, 2'b00, 2'b01, 0);
      9:  return mk(4'd9,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 0);
      10: return mk(4'd10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      11: return mk(4'd11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 0);
      default: return '0;
    endcase
  endfunction

  // One clock cycle: apply inputs just after the edge and queue what must be seen this cycle.
  task automatic step(input logic [5:0] op, input logic rdy, input logic rst, input int st,
                      input logic ill);
    reset    = rst;
    opCode   = op;
    memReady = rdy;
    q_exp.push_back(exp_ctl(st, rdy, rst, ill));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    ctl_t act;
    ctl_t exp;
    act = mk(state, pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memtoReg,
             aluSrcA, regWrite, regDst, pcSource, aluSrcB, aluOp, illegalOp);
    if (q_exp.size() > 0) begin
      exp = q_exp.pop_front();
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL ctl_word t=%0t actual=%b required=%b", $time, act, exp);
    end
    n_checks++;
    if (!((memRead && memWrite) || (regWrite && memWrite))) n_pass++;
    else $display("FAIL exclusive_enables t=%0t actual=%b required=no overlap", $time, act);
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    opCode   = 6'b000000;
    memReady = 1'b0;
    @(posedge clk);
    #1;
    // Held in reset across clocks
    step(6'b100011, 1, 1, 0, 0);
    step(6'b100011, 1, 1, 0, 0);
    // R-type, opcode wiggled outside DECODE has no effect
    step(6'b100011, 1, 0, 0, 0);
    step(6'b000000, 1, 0, 1, 0);
    step(6'b000100, 1, 0, 6, 0);
    step(6'b000010, 1, 0, 7, 0);
    // lw with FETCH wait and 3-cycle MEMRD wait
    step(6'b100011, 0, 0, 0, 0);
    step(6'b100011, 1, 0, 0, 0);
    step(6'b100011, 1, 0, 1, 0);
    step(6'b100011, 1, 0, 2, 0);
    step(6'b100011, 0, 0, 3, 0);
    step(6'b100011, 0, 0, 3, 0);
    step(6'b100011, 0, 0, 3, 0);
    step(6'b100011, 1, 0, 3, 0);
    step(6'b101011, 1, 0, 4, 0);
    // sw with one MEMWR wait
    step(6'b101011, 1, 0, 0, 0);
    step(6'b101011, 1, 0, 1, 0);
    step(6'b101011, 1, 0, 2, 0);
    step(6'b101011, 0, 0, 5, 0);
    step(6'b101011, 1, 0, 5, 0);
    // beq then j
    step(6'b000100, 1, 0, 0, 0);
    step(6'b000100, 1, 0, 1, 0);
    step(6'b000100, 1, 0, 8, 0);
    step(6'b000010, 1, 0, 0, 0);
    step(6'b000010, 1, 0, 1, 0);
    step(6'b000010, 1, 0, 11, 0);
    // addi
    step(6'b001000, 1, 0, 0, 0);
    step(6'b001000, 1, 0, 1, 0);
    step(6'b001000, 1, 0, 9, 0);
    step(6'b001000, 1, 0, 10, 0);
    // illegal opcode
    step(6'b111111, 1, 0, 0, 0);
    step(6'b111111, 1, 0, 1, 1);
    step(6'b111111, 1, 0, 0, 0);
    step(6'b000000, 1, 0, 1, 0);
    step(6'b000000, 1, 0, 6, 0);
    step(6'b000000, 1, 0, 7, 0);
    // async reset mid-wait in MEMRD, asserted between edges
    step(6'b100011, 1, 0, 0, 0);
    step(6'b100011, 1, 0, 1, 0);
    step(6'b100011, 1, 0, 2, 0);
    step(6'b100011, 0, 0, 3, 0);
    step(6'b100011, 0, 1, 0, 0);
    step(6'b100011, 1, 0, 0, 0);
    step(6'b100011, 1, 0, 1, 0);
    step(6'b100011, 1, 0, 2, 0);
    step(6'b100011, 1, 0, 3, 0);
    step(6'b100011, 1, 0, 4, 0);
    step(6'b100011, 1, 0, 0, 0);
    @(negedge clk);
    #1;
    n_checks++;
    if (q_exp.size() == 0) n_pass++;
    else $display("FAIL queue_drained actual=%0d required=0", q_exp.size());
    stim_done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/control_multiciclo.md
CONTROL_MULTICICLO -- requirements
Module: controlMulticiclo

Interface
REQ-001 Parameter OPCODE_W, default 6: opcode field width; decode constants are zero-extended to OPCODE_W.
REQ-002 Parameter ALUOP_W, default 2: aluOp width; codes 00 add, 01 sub, 10 funct-decoded, with upper bits zero.
REQ-003 Parameter MEM_HANDSHAKE, default 1: 1 = memory accesses wait for memReady; 0 = memReady ignored and treated as 1.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 opCode  input  OPCODE_W  instruction opcode from the instruction register.
REQ-008 memReady  input  1  memory completion strobe for the current access.
REQ-009 pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memtoReg, aluSrcA, regWrite, regDst  output  1 each  datapath controls.
REQ-010 pcSource  output  2  PC mux select: 00 ALU, 01 aluOut, 10 jump target.
REQ-011 aluSrcB  output  2  ALU B select: 00 reg B, 01 const 4, 10 sign-ext imm, 11 shifted imm.
REQ-012 aluOp  output  ALUOP_W  ALU control class.
REQ-013 state  output  4  current state encoding, for debug.
REQ-014 illegalOp  output  1  single-cycle flag for an unsupported opcode.

Function
REQ-015 States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BEQ 8, ADDIEX 9, ADDIWB 10, JUMP 11.
REQ-016 Codes 12-15 are illegal states and SHALL transition to FETCH on the next clock with all outputs 0.
REQ-017 Outputs SHALL be a combinational decode of state, gated by memReady where stated; any control not listed for a state is 0.
REQ-018 FETCH outputs: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00; irWrite=pcWrite=memReady.
REQ-019 FETCH transition: stay in FETCH while memReady=0; go to DECODE when memReady=1.
REQ-020 DECODE outputs: aluSrcA=0, aluSrcB=11, aluOp=00.
REQ-021 DECODE transitions, by opCode:
- 000000 -> EXEC
- 100011 or 101011 -> MEMADR
- 000100 -> BEQ
- 001000 -> ADDIEX
- 000010 -> JUMP
- any other value -> FETCH, with illegalOp=1 for that DECODE cycle only.
REQ-022 MEMADR outputs: aluSrcA=1, aluSrcB=10, aluOp=00.
REQ-023 MEMADR transitions: opCode 100011 -> MEMRD; otherwise -> MEMWR.
REQ-024 MEMRD outputs: memRead=1, iorD=1.
REQ-025 MEMRD transition: stay while memReady=0; -> MEMWB when memReady=1.
REQ-026 MEMWB outputs: regWrite=1, memtoReg=1, regDst=0; next state FETCH.
REQ-027 MEMWR outputs: memWrite=1, iorD=1.
REQ-028 MEMWR transition: stay while memReady=0; -> FETCH when memReady=1.
REQ-029 EXEC outputs: aluSrcA=1, aluSrcB=00, aluOp=10; next state RWB.
REQ-030 RWB outputs: regWrite=1, regDst=1, memtoReg=0; next state FETCH.
REQ-031 BEQ outputs: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01; next state FETCH.
REQ-032 ADDIEX outputs: aluSrcA=1, aluSrcB=10, aluOp=00; next state ADDIWB.
REQ-033 ADDIWB outputs: regWrite=1, regDst=0, memtoReg=0; next state FETCH.
REQ-034 JUMP outputs: pcWrite=1, pcSource=10; next state FETCH.
REQ-035 memWrite and memRead SHALL never both be 1, and regWrite and memWrite SHALL never both be 1, in any cycle.
REQ-036 opCode SHALL be sampled only in DECODE and MEMADR; changes in other states have no effect.
REQ-037 Cycle counts with memReady tied high: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3, illegal 2.

Reset
REQ-038 reset=1 SHALL force state=FETCH immediately, without waiting for clk, and hold all outputs at 0 while asserted, including mid-instruction and mid-wait.
REQ-039 On the first rising clk edge after reset deasserts, the block SHALL be in FETCH with FETCH outputs active.

Verification
REQ-040 memReady=1, opCode=000000 -> states 0,1,6,7,0; regWrite=1 and regDst=1 only in state 7.
REQ-041 MEM_HANDSHAKE=1, opCode=100011, memReady low for 3 cycles in MEMRD -> state holds 3 for 4 cycles, then 4 with memtoReg=1; no irWrite outside FETCH.
REQ-042 opCode=101011 -> states 0,1,2,5,0; memWrite=1 only in state 5; regWrite=0 throughout.
REQ-043 opCode=000100, then 000010 -> states 0,1,8,0,1,11,0; pcWriteCond=1 in 8; pcWrite=1 and pcSource=10 in 11.
REQ-044 opCode=111111 -> illegalOp=1 for exactly one cycle in state 1, then state 0; no write enables asserted.
REQ-045 reset pulsed asynchronously in state 3 -> state=0 and all outputs 0 before the next clk edge; normal fetch resumes after release.
